// File: rtl/trace_uart_streamer.sv
// Buffers 36-bit CPU trace words in a FIFO and streams each one as five
// little-endian UART bytes. The last byte carries a 4'hA frame marker. A latched trap stops intake and reports drain.
module trace_uart_streamer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [35:0]                   trace_data,
  input  logic                          trace_valid,
  input  logic                          trap,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          drained
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q;
  logic [35:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     ovf_q;
  logic            trap_q;
  logic [35:0]     frame_q;
  logic [2:0]      idx_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;

  logic            empty, full, trap_eff, pop, push, drop, hshk;
  logic [35:0]     head;

  function automatic logic [7:0] frame_byte(input logic [35:0] w, input logic [2:0] i);
    case (i)
      3'd0:    frame_byte = w[7:0];
      3'd1:    frame_byte = w[15:8];
      3'd2:    frame_byte = w[23:16];
      3'd3:    frame_byte = w[31:24];
      default: frame_byte = {4'hA, w[35:32]};
    endcase
  endfunction

  // A trap seen this cycle already blocks the word presented alongside it.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == FULL_LVL);
    trap_eff = trap | trap_q;
    pop      = (state_q == IDLE) && !empty;
    push     = trace_valid && !trap_eff && (!full || pop);
    drop     = trace_valid && !trap_eff && full && !pop;
    hshk     = tx_valid_q && tx_ready;
    head     = mem_q[rd_ptr_q];
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      trap_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      if (trap) trap_q <= 1'b1;
    end
  end

  // Storage carries no reset; pointers and level alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= trace_data;
    if (pop)  frame_q <= head;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            tx_data_q  <= head[7:0];
            idx_q      <= 3'd0;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            tx_valid_q <= 1'b0;
          end
        end
        SEND: begin
          if (hshk) begin
            if (idx_q == 3'd4) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= frame_byte(frame_q, idx_q + 3'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign drained        = trap_q && empty && (state_q == IDLE);
endmodule
